// File: rtl/cfu_simd_mac_acc.sv
// int8 SIMD multiply-accumulate CFU: staged A/B operand buffers reduced into a 32-bit accumulator.
// Define CFU_MAC_SAT_EN to saturate each per-cycle accumulator update instead of wrapping.
module cfu_simd_mac_acc #(
  parameter int unsigned LANES = 8,
  parameter int unsigned LPC   = 4,
  parameter int unsigned OFF_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int unsigned Words  = LANES / 4;
  localparam int unsigned Chunks = LANES / LPC;
  localparam int unsigned PtrW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned ChunkW = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int unsigned LaneW  = $clog2(LANES);

  localparam logic [6:0] OpMac       = 7'd0;
  localparam logic [6:0] OpSetOffset = 7'd1;
  localparam logic [6:0] OpLoad      = 7'd2;
  localparam logic [6:0] OpReadAcc   = 7'd3;
  localparam logic [6:0] OpClear     = 7'd4;
  localparam logic [6:0] OpSetBias   = 7'd5;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                   state_q;
  logic [31:0]              acc_q;
  logic signed [OFF_W-1:0]  offset_q;
  logic [PtrW-1:0]          ptr_q;
  logic [ChunkW-1:0]        chunk_q;
  logic [Words-1:0][31:0]   a_q;
  logic [Words-1:0][31:0]   b_q;

  logic [6:0]               funct7;
  logic [2:0]               unused_funct_lo;
  logic [LANES-1:0][7:0]    a_lanes;
  logic [LANES-1:0][7:0]    b_lanes;
  logic [LaneW-1:0]         lane_idx;
  logic signed [7:0]        a_byte;
  logic signed [7:0]        b_byte;
  logic signed [OFF_W:0]    sum_s;
  logic signed [OFF_W+8:0]  prod_s;
  logic signed [32:0]       part;
  logic signed [32:0]       acc_sum;
  logic [31:0]              acc_mac;

  assign funct7          = cmd_payload_function_id[9:3];
  assign unused_funct_lo = cmd_payload_function_id[2:0];
  assign cmd_ready       = (state_q == StIdle);
  assign a_lanes         = a_q;
  assign b_lanes         = b_q;

  // One chunk of LPC lanes per BUSY cycle, reduced in 33 bits before touching acc.
  always_comb begin
    part     = '0;
    lane_idx = '0;
    a_byte   = '0;
    b_byte   = '0;
    sum_s    = '0;
    prod_s   = '0;
    for (int l = 0; l < int'(LPC); l++) begin
      lane_idx = LaneW'(int'(chunk_q) * int'(LPC) + l);
      a_byte   = a_lanes[lane_idx];
      b_byte   = b_lanes[lane_idx];
      sum_s    = {{(OFF_W - 7){a_byte[7]}}, a_byte} + {offset_q[OFF_W-1], offset_q};
      prod_s   = sum_s * b_byte;
      part     = part + 33'(prod_s);
    end
    acc_sum = {acc_q[31], acc_q} + part;
  end

`ifdef CFU_MAC_SAT_EN
  always_comb begin
    if (acc_sum[32] != acc_sum[31]) begin
      acc_mac = acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      acc_mac = acc_sum[31:0];
    end
  end
`else
  logic unused_carry;
  assign unused_carry = acc_sum[32];
  assign acc_mac      = acc_sum[31:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q               <= StIdle;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      acc_q                 <= '0;
      offset_q              <= '0;
      ptr_q                 <= '0;
      chunk_q               <= '0;
      a_q                   <= '0;
      b_q                   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (funct7 == OpMac) begin
              state_q <= StBusy;
              chunk_q <= '0;
            end else begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              case (funct7)
                OpSetOffset: begin
                  offset_q              <= cmd_payload_inputs_0[OFF_W-1:0];
                  acc_q                 <= '0;
                  rsp_payload_outputs_0 <= '0;
                end
                OpLoad: begin
                  a_q[ptr_q]            <= cmd_payload_inputs_0;
                  b_q[ptr_q]            <= cmd_payload_inputs_1;
                  rsp_payload_outputs_0 <= 32'(ptr_q);
                  ptr_q <= (ptr_q == PtrW'(Words - 1)) ? '0 : ptr_q + 1'b1;
                end
                OpReadAcc: rsp_payload_outputs_0 <= acc_q;
                OpClear: begin
                  rsp_payload_outputs_0 <= acc_q;
                  acc_q                 <= '0;
                  ptr_q                 <= '0;
                end
                OpSetBias: begin
                  acc_q                 <= cmd_payload_inputs_0;
                  rsp_payload_outputs_0 <= cmd_payload_inputs_0;
                end
                default: rsp_payload_outputs_0 <= '0;
              endcase
            end
          end
        end
        StBusy: begin
          acc_q <= acc_mac;
          if (chunk_q == ChunkW'(Chunks - 1)) begin
            state_q               <= StResp;
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= acc_mac;
            chunk_q               <= '0;
          end else begin
            chunk_q <= chunk_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac_acc.sv
// Directed bench for cfu_simd_mac_acc (LANES=8, LPC=4) with hand-computed expectations.
module tb_cfu_simd_mac_acc;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  int vectors = 0;
  int errors  = 0;

  cfu_simd_mac_acc #(.LANES(8), .LPC(4), .OFF_W(16)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and collect its response; lat = posedges after the accepting edge.
  task automatic issue(input logic [6:0] f, input logic [31:0] i0, input logic [31:0] i1,
                       output logic [31:0] rsp, output int lat);
    int n;
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f, 3'b101};
    cmd_payload_inputs_0    = i0;
    cmd_payload_inputs_1    = i1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      vectors++;
      errors++;
      $display("FAIL timeout f=%0d: rsp_valid=%b required 1", f, rsp_valid);
    end
    rsp = rsp_payload_outputs_0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int lat;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    vectors++;
    if (rsp_payload_outputs_0 !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_payload_outputs_0);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    issue(7'd3, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL reset_read_acc: got %h want 0", r);
    end
    vectors++;
    if (lat !== 0) begin
      errors++; $display("FAIL read_acc_latency: got %0d want 0", lat);
    end
  endtask

  task automatic test_mac_offset();
    logic [31:0] r;
    int lat;
    issue(7'd1, 32'd128, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL set_offset_rsp: got %h want 0", r);
    end
    issue(7'd2, 32'h8080_8080, 32'h0101_0101, r, lat);
    vectors++;
    if (r !== 32'd0) begin
      errors++; $display("FAIL load0_rsp: got %0d want 0", r);
    end
    issue(7'd2, 32'h7F7F_7F7F, 32'h0202_0202, r, lat);
    vectors++;
    if (r !== 32'd1) begin
      errors++; $display("FAIL load1_rsp: got %0d want 1", r);
    end
    issue(7'd0, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'd2040) begin
      errors++; $display("FAIL mac_offset_rsp: got %h want 7f8", r);
    end
    vectors++;
    if (lat !== 2) begin
      errors++; $display("FAIL mac_latency: got %0d want 2", lat);
    end
  endtask

  task automatic test_ptr_wrap();
    logic [31:0] r;
    int lat;
    issue(7'd4, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'd2040) begin
      errors++; $display("FAIL clear_rsp: got %h want 7f8", r);
    end
    issue(7'd1, 32'd0, 32'h0, r, lat);
    issue(7'd2, 32'h0101_0101, 32'h0101_0101, r, lat);
    vectors++;
    if (r !== 32'd0) begin
      errors++; $display("FAIL wrap_load_a: got %0d want 0", r);
    end
    issue(7'd2, 32'h0202_0202, 32'h0303_0303, r, lat);
    vectors++;
    if (r !== 32'd1) begin
      errors++; $display("FAIL wrap_load_b: got %0d want 1", r);
    end
    issue(7'd2, 32'h0404_0404, 32'h0505_0505, r, lat);
    vectors++;
    if (r !== 32'd0) begin
      errors++; $display("FAIL wrap_load_c: got %0d want 0", r);
    end
    // word0 now 4*5 per lane, word1 2*3 per lane: 4*20 + 4*6
    issue(7'd0, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'd104) begin
      errors++; $display("FAIL wrap_mac: got %0d want 104", r);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int lat;
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd3, 3'b000};
    @(negedge clk);
    // Keep offering SET_BIAS while the READ_ACC response is stalled.
    cmd_payload_function_id = {7'd5, 3'b000};
    cmd_payload_inputs_0    = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== 32'd104 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b data=%0d ready=%b want 1/104/0", i, rsp_valid,
                 rsp_payload_outputs_0, cmd_ready);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: rsp_valid=%b want 0", rsp_valid);
    end
    issue(7'd3, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'd104) begin
      errors++; $display("FAIL stall_no_extra_cmd: got %h want 68", r);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [31:0] want;
    int lat;
`ifdef CFU_MAC_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8001_F708;
`endif
    issue(7'd1, 32'd0, 32'h0, r, lat);
    issue(7'd5, 32'h7FFF_FF00, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h7FFF_FF00) begin
      errors++; $display("FAIL set_bias_rsp: got %h want 7fffff00", r);
    end
    issue(7'd2, 32'h7F7F_7F7F, 32'h7F7F_7F7F, r, lat);
    vectors++;
    if (r !== 32'd1) begin
      errors++; $display("FAIL ovf_load_ptr: got %0d want 1", r);
    end
    issue(7'd2, 32'h7F7F_7F7F, 32'h7F7F_7F7F, r, lat);
    issue(7'd0, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== want) begin
      errors++; $display("FAIL overflow_mac: got %h want %h", r, want);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic        seen;
    int lat;
    issue(7'd5, 32'd5, 32'h0, r, lat);
    @(negedge clk);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd0, 3'b000};
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL busy_cmd_ready: got %b want 0", cmd_ready);
    end
    reset_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_rsp_valid: got %b want 0", seen);
    end
    issue(7'd3, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL abort_read_acc: got %h want 0", r);
    end
    issue(7'h7F, 32'hDEAD_BEEF, 32'hCAFE_F00D, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL unknown_op: got %h want 0", r);
    end
    // Buffers were cleared by reset, so a MAC now yields zero.
    issue(7'd0, 32'h0, 32'h0, r, lat);
    vectors++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL mac_after_reset: got %h want 0", r);
    end
  endtask

  initial begin
    reset_n                 = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    test_reset();
    test_mac_offset();
    test_ptr_wrap();
    test_backpressure();
    test_overflow();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
